// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO pair.
// Executes MULT, MULTU, DIV, DIVU (one radix-2 step per clock) and MTHI/MTLO.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        request strobe, sampled on the rising edge of clk
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         rs / rt operands
//   busy         high while a mult/div is in flight
//   done         one-cycle pulse when HI/LO receive a mult/div result
//   div_by_zero  pulses together with done when a divide had b == 0
//   hi, lo       HI and LO registers
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
//   CALC  | one shift-add / shift-subtract step per cycle, WIDTH steps
//   FIX   | sign correction, HI/LO write, done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // product, or quotient in the low half
  logic [WIDTH-1:0]   rem;      // partial remainder (always < divisor)
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_raw;    // original dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_q;    // negate product / quotient
  logic               neg_r;    // negate remainder
  logic               dz;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // The shifted remainder can need WIDTH+1 bits, but whenever the divisor
    // fits the difference is below the divisor, so WIDTH bits hold it.
    div_shift = {rem, acc[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;

    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opnd   <= a_mag;
                acc    <= {{WIDTH{1'b0}}, b_mag};
                rem    <= '0;
                is_div <= 1'b0;
                neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= 1'b0;
                dz     <= 1'b0;
                cnt    <= CW'(WIDTH - 1);
                busy   <= 1'b1;
                state  <= CALC;
              end
              OP_DIV, OP_DIVU: begin
                opnd   <= b_mag;
                acc    <= {{WIDTH{1'b0}}, a_mag};
                rem    <= '0;
                a_raw  <= a;
                is_div <= 1'b1;
                neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= signed_op && a[WIDTH-1];
                dz     <= (b == '0);
                cnt    <= CW'(WIDTH - 1);
                busy   <= 1'b1;
                state  <= CALC;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end

        CALC: begin
          if (is_div) begin
            rem              <= div_fits ? div_diff : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_fits};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        FIX: begin
          if (is_div) begin
            if (dz) begin
              hi          <= a_raw;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH = 32): directed vector table plus
// sequences for MTHI/MTLO, start-while-busy, back-to-back and async reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Issues v immediately (caller positions time away from the edge), then
  // follows it to the done cycle. With poke set, an MTLO is strobed mid-CALC.
  task automatic run_vec(input vec_t v, input bit poke, input string tag);
    logic [31:0] h0;
    logic [31:0] l0;
    int          n;
    bit          held;
    bit          busy_ok;
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 3'b011;
    chk({tag, " accept"}, 64'({busy, done, div_by_zero}), 64'(3'b100));
    held    = 1'b1;
    busy_ok = 1'b1;
    n       = 0;
    while (n < 100) begin
      if (poke && n == 10) begin
        start = 1'b1;
        op    = 3'b101;
        a     = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    chk({tag, " latency"}, 64'(n), 64'(33));
    chk({tag, " busy_during"}, 64'(busy_ok), 64'(1));
    chk({tag, " hilo_held"}, 64'(held), 64'(1));
    chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, " hi"}, 64'(hi), 64'(v.hi));
    chk({tag, " lo"}, 64'(lo), 64'(v.lo));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(v.dz));
  endtask

  initial begin
    vec_t v;
    n_pass  = 0;
    n_total = 0;

    //            op      a             b             hi            lo            dz
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[10] = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({busy, done, div_by_zero}), 64'(0));
    chk("reset hi_lo", {hi, lo}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO while idle
    start = 1'b1;
    op    = 3'b100;
    a     = 32'h12345678;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mthi hi", 64'(hi), 64'(32'h12345678));
    chk("mthi busy_done", 64'({busy, done}), 64'(0));
    @(negedge clk);
    start = 1'b1;
    op    = 3'b101;
    a     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo lo", 64'(lo), 64'(32'hCAFEF00D));
    chk("mtlo hi_kept", 64'(hi), 64'(32'h12345678));
    @(negedge clk);

    // MULT with an MTLO strobed mid-CALC: must be ignored
    v = '{3'b000, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 1'b0};
    run_vec(v, 1'b1, "mult_mtlo_poke");

    // Table; odd entries issue in the done cycle of the previous op
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) repeat (2) @(negedge clk);
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end
    @(posedge clk);
    #1;
    chk("pulse_end", 64'({done, div_by_zero}), 64'(0));

    // Async reset at CALC step 10 of a DIV
    @(negedge clk);
    start = 1'b1;
    op    = 3'b010;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset busy_done", 64'({busy, done, div_by_zero}), 64'(0));
    chk("midreset hi_lo", {hi, lo}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    v = '{3'b000, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
    run_vec(v, 1'b0, "post_reset_mult");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
